smg_scan_control_module: RTL and testbench



---
 rtl/smg_pkg.sv | 45 ++++
 rtl/smg_scan_timer_module.sv | 51 +++++
 rtl/smg_scan_control_module.sv | 113 +++++++++++
 tb/tb_smg_scan_control_module.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scan controller and its encoder.
package smg_pkg;

    // Width of one BCD digit inside the packed value.
    localparam int BCD_W = 4;

    // Phase of the current digit slot: all digits off, then one digit on.
    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_t;

    // Common-anode segment codes (active-low, bit 7 = decimal point).
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit code to segment pattern; codes above 9 have no glyph.
    function automatic logic [7:0] seg_code(input logic [BCD_W-1:0] n);
        logic [7:0] s;
        case (n)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/smg_scan_timer_module.sv
// Digit slot timer: counts SCAN_CNT cycles per slot, the first BLANK_CNT
// of which are the blank phase. The phase register is the slot FSM.
module smg_scan_timer_module
    import smg_pkg::*;
#(
    parameter int SCAN_CNT  = 50000,
    parameter int BLANK_CNT = 500
) (
    input  logic CLK,
    input  logic RST,
    output logic Slot_End,
    output logic Show_Phase
);

    localparam int CW = $clog2(SCAN_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CNT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    scan_state_t   state_q;
    scan_state_t   state_d;

    // Slot counter and phase register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q   <= '0;
            state_q <= ST_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Next count wraps at slot end; phase follows the next count's compare.
    always_comb begin
        cnt_d   = cnt_q + CNT_ONE;
        state_d = ST_BLANK;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
        if (cnt_d >= CNT_SHOW) begin
            state_d = ST_SHOW;
        end
    end

    assign Slot_End   = (cnt_q == CNT_LAST);
    assign Show_Phase = (state_q == ST_SHOW);

endmodule

// File: rtl/smg_scan_control_module.sv
// Multiplexed scan controller for a common-anode seven-segment display.
// Load_En is a fire-and-forget request with no ready: a value sampled with
// Load_En=1 is held as pending and becomes visible at the next frame
// boundary; a later request before that boundary replaces it.
module smg_scan_control_module
    import smg_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int SCAN_CNT  = 50000,
    parameter int BLANK_CNT = 500
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    Load_En,
    input  logic [BCD_W*DIGITS-1:0] Value_Data,
    input  logic                    Blank_Lz,
    output logic [BCD_W-1:0]        Number_Data,
    output logic [DIGITS-1:0]       Scan_Data,
    output logic                    Frame_Done
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    logic                    slot_end;
    logic                    show_phase;
    logic                    frame_wrap;
    logic [IW-1:0]           idx_q;
    logic                    frame_q;
    logic [BCD_W*DIGITS-1:0] disp_q;
    logic                    lz_q;
    logic [BCD_W*DIGITS-1:0] pend_q;
    logic                    pend_lz_q;
    logic                    pend_vld_q;
    logic [DIGITS-1:0]       vis;
    logic                    upper_zero;
    logic [BCD_W-1:0]        nib;

    smg_scan_timer_module #(
        .SCAN_CNT  (SCAN_CNT),
        .BLANK_CNT (BLANK_CNT)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .Slot_End   (slot_end),
        .Show_Phase (show_phase)
    );

    // The last slot of the last digit ends the frame.
    assign frame_wrap = slot_end && (idx_q == IDX_LAST);

    // Digit index advances at every slot end; Frame_Done marks the wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_wrap;
            if (slot_end) begin
                idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_ONE;
            end
        end
    end

    // Pending capture and frame-synchronous transfer to the display register.
    // A load coinciding with the wrap keeps the pending flag for next frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            disp_q     <= '0;
            lz_q       <= 1'b0;
            pend_q     <= '0;
            pend_lz_q  <= 1'b0;
            pend_vld_q <= 1'b0;
        end else begin
            if (frame_wrap && pend_vld_q) begin
                disp_q <= pend_q;
                lz_q   <= pend_lz_q;
            end
            if (Load_En) begin
                pend_q     <= Value_Data;
                pend_lz_q  <= Blank_Lz;
                pend_vld_q <= 1'b1;
            end else if (frame_wrap) begin
                pend_vld_q <= 1'b0;
            end
        end
    end

    // Per-digit visibility: non-BCD codes and suppressed leading zeros hide.
    always_comb begin
        vis        = '0;
        upper_zero = 1'b1;
        nib        = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib        = disp_q[i*BCD_W +: BCD_W];
            upper_zero = upper_zero && (nib == 4'd0);
            vis[i]     = (nib <= 4'd9) && !(lz_q && (i > 0) && upper_zero);
        end
    end

    // Select line of the current digit goes low only in its show phase.
    always_comb begin
        Scan_Data = '1;
        if (show_phase && vis[idx_q]) begin
            Scan_Data[idx_q] = 1'b0;
        end
    end

    assign Number_Data = disp_q[int'(idx_q)*BCD_W +: BCD_W];
    assign Frame_Done  = frame_q;

endmodule

// File: tb/tb_smg_scan_control_module.sv
// Bench for the scan controller with DIGITS=4, SCAN_CNT=8, BLANK_CNT=2.
module tb_smg_scan_control_module;

    localparam int DIGITS    = 4;
    localparam int SCAN_CNT  = 8;
    localparam int BLANK_CNT = 2;
    localparam int FRAME     = DIGITS * SCAN_CNT;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Load_En;
    logic [15:0] Value_Data;
    logic        Blank_Lz;
    logic [3:0]  Number_Data;
    logic [3:0]  Scan_Data;
    logic        Frame_Done;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [15:0] value;
        logic        lz;
        logic [3:0]  mask;
    } vec_t;

    vec_t vecs[8];

    smg_scan_control_module #(
        .DIGITS    (DIGITS),
        .SCAN_CNT  (SCAN_CNT),
        .BLANK_CNT (BLANK_CNT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Load_En     (Load_En),
        .Value_Data  (Value_Data),
        .Blank_Lz    (Blank_Lz),
        .Number_Data (Number_Data),
        .Scan_Data   (Scan_Data),
        .Frame_Done  (Frame_Done)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic load(input logic [15:0] value, input logic lz);
        Value_Data = value;
        Blank_Lz   = lz;
        Load_En    = 1'b1;
        @(negedge CLK);
        Load_En    = 1'b0;
    endtask

    task automatic wait_fd(input string name);
        int n = 0;
        while (Frame_Done !== 1'b1 && n < 4 * FRAME) begin
            @(negedge CLK);
            n++;
        end
        check({name, " wait_frame_done"}, 16'(Frame_Done), 16'h1);
    endtask

    // Called on the first cycle of a frame; checks that frame cycle by cycle
    // and ends on the first cycle of the following frame.
    task automatic check_frame(input logic [15:0] value, input logic [3:0] mask,
                               input logic fd0, input string tag);
        logic [3:0] sel;
        logic [3:0] scan;
        logic [8:0] e;
        int slot;
        int ph;
        for (int c = 0; c < FRAME; c++) begin
            slot = c / SCAN_CNT;
            ph   = c % SCAN_CNT;
            sel  = 4'b0001 << slot;
            scan = (ph >= BLANK_CNT && mask[slot]) ? ~sel : 4'hF;
            exp_q.push_back({(c == 0) ? fd0 : 1'b0, value[slot*4 +: 4], scan});
        end
        for (int c = 0; c < FRAME; c++) begin
            e = exp_q.pop_front();
            check($sformatf("%s c%0d {fd,num,scan}", tag, c),
                  16'({Frame_Done, Number_Data, Scan_Data}), 16'(e));
            @(negedge CLK);
            Load_En = 1'b0;
        end
        check({tag, " frame_period"}, 16'(Frame_Done), 16'h1);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 4'b1111};
        vecs[1] = '{16'h0050, 1'b1, 4'b0011};
        vecs[2] = '{16'h0000, 1'b1, 4'b0001};
        vecs[3] = '{16'h12A4, 1'b0, 4'b1101};
        vecs[4] = '{16'h0050, 1'b0, 4'b1111};
        vecs[5] = '{16'h0B07, 1'b1, 4'b0011};
        vecs[6] = '{16'h9000, 1'b1, 4'b1111};
        vecs[7] = '{16'h000F, 1'b0, 4'b1110};

        RST        = 1'b1;
        Load_En    = 1'b0;
        Value_Data = 16'h0;
        Blank_Lz   = 1'b0;
        step(3);
        check("reset {fd,num,scan}", 16'({Frame_Done, Number_Data, Scan_Data}), 16'h00F);
        RST = 1'b0;

        // Free-running first frame shows zeros, no pulse on its first cycle.
        check_frame(16'h0000, 4'b1111, 1'b0, "post_reset");

        for (int v = 0; v < 8; v++) begin
            step(2);
            load(vecs[v].value, vecs[v].lz);
            wait_fd($sformatf("vec%0d", v));
            check_frame(vecs[v].value, vecs[v].mask, 1'b1, $sformatf("vec%0d", v));
        end
        // No load: display is held.
        check_frame(16'h000F, 4'b1110, 1'b1, "hold");

        // Overwrite within a frame, then a load during the Frame_Done cycle.
        step(2);
        load(16'h1111, 1'b0);
        step(3);
        load(16'h2222, 1'b0);
        wait_fd("ovr");
        Value_Data = 16'h3333;
        Load_En    = 1'b1;
        check_frame(16'h2222, 4'b1111, 1'b1, "ovr_a");
        check_frame(16'h3333, 4'b1111, 1'b1, "ovr_b");

        // Load sampled on the wrap edge while another value is pending.
        step(2);
        load(16'h5555, 1'b0);
        step(FRAME - 4);
        Value_Data = 16'h4444;
        Load_En    = 1'b1;
        @(negedge CLK);
        Load_En    = 1'b0;
        check_frame(16'h5555, 4'b1111, 1'b1, "edge_a");
        check_frame(16'h4444, 4'b1111, 1'b1, "edge_b");

        // Reset in the show phase of digit 2 with a load pending.
        step(2);
        load(16'h9999, 1'b0);
        step(2 * SCAN_CNT + 4 - 3);
        check("pre_rst scan", 16'(Scan_Data), 16'hB);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check("mid_rst {fd,num,scan}", 16'({Frame_Done, Number_Data, Scan_Data}), 16'h00F);
        check_frame(16'h0000, 4'b1111, 1'b0, "rst_frame");
        check_frame(16'h0000, 4'b1111, 1'b1, "rst_discard");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
